// File: rtl/read_query_arbiter.sv
// Round-robin arbiter that shares the read-RAM query port between N_REQ lanes and routes each
// returned base to its owning lane. Define QUERY_ARB_PERF_EN to add grant/stall perf counters.
module read_query_arbiter #(
  parameter int N_REQ          = 4,
  parameter int READ_NUM_WIDTH = 8,
  parameter int MAX_OUT        = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall,
  input  logic                             load_done,
  input  logic [N_REQ-1:0]                 req_valid,
  output logic [N_REQ-1:0]                 req_ready,
  input  logic [6*N_REQ-1:0]               req_status,
  input  logic [7*N_REQ-1:0]               req_position,
  input  logic [READ_NUM_WIDTH*N_REQ-1:0]  req_read_num,
  output logic [5:0]                       status_query,
  output logic [6:0]                       query_position,
  output logic [READ_NUM_WIDTH-1:0]        query_read_num,
  input  logic [7:0]                       new_read_query,
  output logic [N_REQ-1:0]                 resp_valid,
  output logic [7:0]                       resp_query,
  output logic [6:0]                       resp_position,
`ifdef QUERY_ARB_PERF_EN
  output logic [16*N_REQ-1:0]              perf_grants,
  output logic [15:0]                      perf_stall_cycles,
`endif
  output logic [READ_NUM_WIDTH-1:0]        resp_read_num
);

  localparam int         ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [5:0] BUBBLE  = 6'b110000;
  localparam logic [5:0] F_BREAK = 6'd2;
  localparam logic [5:0] BCK_END = 6'd6;

  typedef struct packed {
    logic                      valid;
    logic [ID_W-1:0]           id;
    logic [6:0]                position;
    logic [READ_NUM_WIDTH-1:0] read_num;
  } tag_t;

  tag_t             tag_q [3];
  tag_t             tag_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [1:0]       cnt_q [N_REQ];
  logic [N_REQ-1:0] no_resp, eligible, cnt_inc;
  logic             grant_valid, grant_no_resp;
  logic [ID_W-1:0]  grant_id;

  function automatic logic is_no_resp(input logic [5:0] s);
    return (s == BUBBLE) || (s == F_BREAK) || (s == BCK_END);
  endfunction

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      no_resp[i]  = is_no_resp(req_status[6*i +: 6]);
      eligible[i] = req_valid[i] && (no_resp[i] || (cnt_q[i] < 2'(MAX_OUT)));
    end
  end

  // Walk offsets from the far end so the lane closest to rr_ptr is the last (winning) write.
  always_comb begin
    logic [ID_W:0] sum;
    logic [ID_W-1:0] idx;
    // NOTE: every output of a combinational block gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    grant_valid = 1'b0;
    grant_id    = '0;
    sum         = '0;
    idx         = '0;
    if (!reset && !stall && load_done) begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
        if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
        idx = sum[ID_W-1:0];
        if (eligible[idx]) begin
          grant_valid = 1'b1;
          grant_id    = idx;
        end
      end
    end
  end

  always_comb begin
    req_ready      = '0;
    status_query   = BUBBLE;
    query_position = '0;
    query_read_num = '0;
    grant_no_resp  = 1'b0;
    cnt_inc        = '0;
    tag_d          = '0;
    rr_ptr_d       = rr_ptr_q;
    if (grant_valid) begin
      req_ready[grant_id] = 1'b1;
      status_query   = req_status[6*int'(grant_id) +: 6];
      query_position = req_position[7*int'(grant_id) +: 7];
      query_read_num = req_read_num[READ_NUM_WIDTH*int'(grant_id) +: READ_NUM_WIDTH];
      grant_no_resp  = no_resp[grant_id];
      rr_ptr_d       = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
      if (!grant_no_resp) begin
        cnt_inc[grant_id] = 1'b1;
        tag_d = '{valid: 1'b1, id: grant_id, position: query_position, read_num: query_read_num};
      end
    end
  end

  always_comb begin
    resp_valid = '0;
    if (tag_q[2].valid && !stall) resp_valid[tag_q[2].id] = 1'b1;
  end

  assign resp_query    = reset ? 8'h00 : new_read_query;
  assign resp_position = tag_q[2].position;
  assign resp_read_num = tag_q[2].read_num;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values; the tag
  // array and counters are individual flops, so reset clears them all and drops in-flight queries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
      for (int s = 0; s < 3; s++) tag_q[s] <= '0;
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else if (!stall) begin
      rr_ptr_q <= rr_ptr_d;
      tag_q[0] <= tag_d;
      tag_q[1] <= tag_q[0];
      tag_q[2] <= tag_q[1];
      for (int i = 0; i < N_REQ; i++) begin
        if (cnt_inc[i] && !resp_valid[i] && cnt_q[i] != 2'(MAX_OUT))
          cnt_q[i] <= cnt_q[i] + 2'd1;
        else if (resp_valid[i] && !cnt_inc[i] && cnt_q[i] != 2'd0)
          cnt_q[i] <= cnt_q[i] - 2'd1;
      end
    end
  end

`ifdef QUERY_ARB_PERF_EN
  logic [15:0] perf_grants_q [N_REQ];
  logic [15:0] perf_stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) perf_grants_q[i] <= '0;
      perf_stall_q <= '0;
    end else begin
      if (grant_valid && perf_grants_q[grant_id] != 16'hFFFF)
        perf_grants_q[grant_id] <= perf_grants_q[grant_id] + 16'd1;
      if (stall && (|req_valid) && perf_stall_q != 16'hFFFF)
        perf_stall_q <= perf_stall_q + 16'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) perf_grants[16*i +: 16] = perf_grants_q[i];
  end
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: doc/read_query_arbiter.md
Name: read_query_arbiter

Overview:
- Shares the single query port of the read RAM (status_query / query_position / query_read_num -> new_read_query, 3-stage extraction pipe) between N_REQ pipeline lanes (forward and backward extenders).
- Per cycle: one round-robin grant, gated by load_done, stall and a per-lane outstanding limit.
- Tags each issued query and routes the returned 8-bit base back to the owning lane, with position and read number.

Parameters:
- N_REQ, 4, number of requesting lanes (2..8)
- READ_NUM_WIDTH, 8, read-number width; matches the RAM
- MAX_OUT, 2, maximum outstanding queries per lane (1..3)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  global pipeline stall; same signal the RAM sees
- load_done  in  1  RAM batch loaded; no grants while low
- req_valid  in  N_REQ  lane i has a query
- req_ready  out  N_REQ  lane i query accepted this cycle
- req_status  in  6*N_REQ  lane i status, slice [6i+5:6i]
- req_position  in  7*N_REQ  lane i query position
- req_read_num  in  READ_NUM_WIDTH*N_REQ  lane i read number
- status_query  out  6  to RAM; BUBBLE (6'b110000) when idle
- query_position  out  7  to RAM
- query_read_num  out  READ_NUM_WIDTH  to RAM
- new_read_query  in  8  registered RAM result
- resp_valid  out  N_REQ  one-hot response strobe
- resp_query  out  8  returned base
- resp_position  out  7  position of the returned query
- resp_read_num  out  READ_NUM_WIDTH  read number of the returned query

Behaviour:
- Eligibility: lane i is eligible when req_valid[i] and its outstanding counter is below MAX_OUT. Requests whose status is BUBBLE, F_break (2) or BCK_END (6) are "no-response": they are always eligible and do not count toward the limit.
- Grant:
  - At most one lane per cycle, and only when !stall and load_done.
  - Round-robin: search starts at rr_ptr. After a grant, rr_ptr <= granted+1, wrapping at N_REQ. rr_ptr is unchanged if there is no grant.
- Port mux: req_ready, status_query, query_position and query_read_num are combinational from the grant.
  - With a grant: the port drives the granted lane's status, position and read_num.
  - With no grant: status_query=BUBBLE, position=0, read_num=0.
- Lane handshake: a lane holds its request stable until req_ready is seen high.
- Tag pipe: 3 stages {valid, lane id, position, read_num}. It advances only when !stall and captures the granted request at stage 1. valid=0 for no-grant and for no-response requests.
- Response: resp_valid[id] = tag3.valid & !stall. resp_query=new_read_query; position and read_num come from tag3.
  - Each response is presented exactly once.
  - Latency: accepted in cycle T, response in cycle T+3 plus the number of stalled cycles.
- Outstanding counters: 2-bit per lane. +1 on an accepted response-generating query, -1 on resp_valid for that lane, unchanged when both happen in the same cycle. A counter never exceeds MAX_OUT or wraps below 0.
- Stall: no grants, req_ready=0, tag pipe and counters frozen, resp_valid=0, rr_ptr held.
- load_done low: port idles (BUBBLE) and the tag pipe still drains.
- Reset, asynchronous and at any time including mid-flight:
  - Cleared: rr_ptr=0, all tags invalid, counters 0.
  - Outputs: req_ready=0, resp_valid=0, status_query=BUBBLE, resp_query/resp_position/resp_read_num=0.
  - In-flight queries are dropped.

Optional Feature:
- Macro: QUERY_ARB_PERF_EN.
- Defined: adds outputs perf_grants (16*N_REQ; per-lane saturating grant counters) and perf_stall_cycles (16, saturating; counts cycles with stall high and any req_valid high). Both clear on reset.
- Undefined: no such ports or logic; behaviour is otherwise identical.

Test Plan:
- Fairness: load_done=1, all 4 lanes valid continuously (with no-response status F_break so the outstanding limit does not apply), no stall -> grants 0,1,2,3,0,... one per cycle; status_query never BUBBLE.
- Latency and routing: lane 2 issues pos=37, read=5 at cycle 10 with RAM model byte 0x43 -> resp_valid=4'b0100 at cycle 13, resp_query=0x43, resp_position=37, resp_read_num=5.
- Limit: MAX_OUT=2, lane 0 only, always valid with status F_run -> accepted cycles 0 and 1, req_ready low until the first response in cycle 3; the counter never reads 3.
- Stall mid-flight: grant at cycle 5, stall high cycles 6-7 -> response at cycle 10, exactly one pulse; no req_ready while stalled.
- No-response status: lane 1 issues BCK_END -> status_query=6 driven for one cycle, no resp_valid for any lane, counter stays 0.
- Reset mid-flight: 3 tags in flight, reset asserted asynchronously -> resp_valid=0 immediately; after release, first grant goes to lane 0 and no stale responses appear.
